status_fifo: RTL and testbench
==============================

# status_fifo

Parametrised synchronous FIFO, successor to the UART byte buffer, for the UART TX/RX paths and other SoC peripherals needing buffered transfer. Adds selectable first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Single clock domain.

## Interface
- DataWidth, 32: bits per entry, ≥1.
- Depth, 16: entries; power of two, ≥2. Elaboration error otherwise.
- FallThrough, 0: 0 = registered read; 1 = FWFT (head word visible on rd_data_o).
- AlmostFullLevel, 14: almost_full_o asserts when count ≥ this; 1..Depth, else elaboration error.
- AlmostEmptyLevel, 2: almost_empty_o asserts when count ≤ this; 0..Depth-1, else elaboration error.
- PointerWidth (localparam) = $clog2(Depth).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of contents and error flags.
- wr_en_i  in  1  write request.
- wr_data_i  in  DataWidth  write data.
- rd_en_i  in  1  read request (FWFT: pop/acknowledge head).
- rd_data_o  out  DataWidth  read data.
- rd_valid_o  out  1  rd_data_o holds valid data.
- full_o  out  1  count == Depth.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count ≥ AlmostFullLevel.
- almost_empty_o  out  1  count ≤ AlmostEmptyLevel.
- count_o  out  PointerWidth+1  occupancy, 0..Depth.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.

## Operation
- Pointers rd_ptr/wr_ptr are PointerWidth+1 bits, MSB is the wrap bit. Address = low PointerWidth bits. Pointers wrap modulo 2·Depth.
- count_o = wr_ptr − rd_ptr, modulo 2^(PointerWidth+1).
- full_o, empty_o, almost_*, count_o are combinational from the pointer registers only, never from the current-cycle requests.
- Accepted write: wr_en_i & !full_o & !flush_i. Stores the word at wr_ptr and increments wr_ptr.
- Accepted read: rd_en_i & !empty_o & !flush_i. Increments rd_ptr.
- Write while full is dropped even if a read is accepted in the same cycle. Read while empty is dropped even if a write is accepted in the same cycle (no bypass).
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- Error flags:
  - overflow_o sets on wr_en_i & full_o & !flush_i.
  - underflow_o sets on rd_en_i & empty_o & !flush_i.
  - Both stay set until flush or reset.
- Flush has priority over everything. It sets both pointers to 0, clears both error flags and rd_valid_o, and ignores rd/wr in that cycle. rd_data_o is not cleared. Memory contents are not cleared.
- FallThrough=0:
  - rd_data_o is registered and loads mem[rd_ptr] on an accepted read.
  - rd_valid_o is a one-cycle pulse in the cycle after each accepted read; it is low otherwise.
- FallThrough=1:
  - rd_data_o = mem[rd_ptr], combinational.
  - rd_valid_o = !empty_o.
  - rd_en_i with rd_valid_o high consumes the displayed word.
- Memory has no reset.

## Timing
- Reset values:
  - rd_ptr = wr_ptr = 0, count_o = 0.
  - empty_o = 1, full_o = 0, almost_full_o = 0, almost_empty_o = 1.
  - overflow_o = underflow_o = 0, rd_valid_o = 0.
  - rd_data_o = 0 in mode 0; don't-care while rd_valid_o = 0 in mode 1.
- Reset is asynchronous assert, synchronous release. Reset mid-transfer discards all contents immediately.
- Write to status latency: flags and count reflect an accepted write after the same clock edge.
- Read latency:
  - Mode 0: data and rd_valid_o appear 1 cycle after the rd_en_i edge.
  - Mode 1: 0 cycles. A word written at edge N is visible on rd_data_o after edge N.
- Full throughput: one write and one read per cycle, sustained.
- Error flags are visible the cycle after the offending request.

## Test plan
- Reset then fill (Depth=16, mode 0): write 0x00..0x0F on consecutive cycles → full_o=1 and count_o=16 after the 16th edge; almost_full_o rises when count reaches 14. A 17th write with value 0xAA → overflow_o=1 and the FIFO still contains 0x00..0x0F in order.
- Drain in mode 0: 16 reads → rd_data_o shows 0x00..0x0F, each one cycle after its rd_en_i, with rd_valid_o pulsed. Then empty_o=1 and almost_empty_o=1. A 17th read → underflow_o=1 and rd_valid_o stays 0.
- Wrap-around: run 40 writes and 40 reads interleaved with count held between 1 and 3 → data returned in order and no flags raised. Simultaneous rd/wr at count 5 → count stays 5.
- FWFT (FallThrough=1): write 0x1234 at edge N → rd_valid_o=1 and rd_data_o=0x1234 after edge N. Assert rd_en_i → empty_o=1 and rd_valid_o=0 after the next edge.
- Full boundary: at count 16 assert rd_en_i and wr_en_i together → read accepted, write dropped, count 15, overflow_o=1. At count 0 assert both → write accepted, read dropped, count 1, underflow_o=1.
- Flush and reset: with count 7 and both error flags set, pulse flush_i together with wr_en_i → count 0, flags cleared, write ignored. Assert rst_ni low mid-burst, asynchronously → all outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/status_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// occupancy/threshold status, sticky overflow/underflow flags and synchronous flush.
module status_fifo #(
    parameter int unsigned DataWidth        = 32,
    parameter int unsigned Depth            = 16,
    parameter int unsigned FallThrough      = 0,
    parameter int unsigned AlmostFullLevel  = 14,
    parameter int unsigned AlmostEmptyLevel = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  logic [DataWidth-1:0]         wr_data_i,
    input  logic                         rd_en_i,
    output logic [DataWidth-1:0]         rd_data_o,
    output logic                         rd_valid_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(Depth):0]       count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);
    localparam int unsigned PointerWidth = $clog2(Depth);
    localparam logic [PointerWidth:0] DepthCnt = (PointerWidth+1)'(Depth);
    localparam logic [PointerWidth:0] AfLevel  = (PointerWidth+1)'(AlmostFullLevel);
    localparam logic [PointerWidth:0] AeLevel  = (PointerWidth+1)'(AlmostEmptyLevel);

    if (DataWidth < 1) begin : g_bad_width
        $error("status_fifo: DataWidth must be >= 1");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("status_fifo: Depth must be a power of two >= 2");
    end
    if (AlmostFullLevel < 1 || AlmostFullLevel > Depth) begin : g_bad_af
        $error("status_fifo: AlmostFullLevel out of range 1..Depth");
    end
    if (AlmostEmptyLevel > Depth - 1) begin : g_bad_ae
        $error("status_fifo: AlmostEmptyLevel out of range 0..Depth-1");
    end

    logic [DataWidth-1:0]    mem_q [Depth];
    logic [PointerWidth:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    overflow_q, overflow_d, underflow_q, underflow_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DataWidth-1:0]    rd_data_q, rd_data_d;
    logic                    wr_acc, rd_acc;
    logic [PointerWidth-1:0] wr_addr, rd_addr;

    // Status is derived from the pointer registers only, never from this cycle's requests.
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign full_o         = (count_o == DepthCnt);
    assign empty_o        = (count_o == '0);
    assign almost_full_o  = (count_o >= AfLevel);
    assign almost_empty_o = (count_o <= AeLevel);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign wr_addr = wr_ptr_q[PointerWidth-1:0];
    assign rd_addr = rd_ptr_q[PointerWidth-1:0];
    assign wr_acc  = wr_en_i & ~full_o & ~flush_i;
    assign rd_acc  = rd_en_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_valid_d  = rd_acc;
        rd_data_d   = rd_data_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            rd_valid_d  = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_addr];
            end
            if (wr_en_i & full_o)  overflow_d  = 1'b1;
            if (rd_en_i & empty_o) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_addr] <= wr_data_i;
    end

    if (FallThrough != 0) begin : g_fwft
        assign rd_data_o  = mem_q[rd_addr];
        assign rd_valid_o = ~empty_o;
    end else begin : g_reg
        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end
endmodule

// File: tb/tb_status_fifo.sv
// Randomised scoreboard bench: registered-read and FWFT instances share stimulus and
// are checked against a queue-based reference model of the FIFO rules.
module tb_status_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, wr_en, rd_en;
    logic [31:0] wr_data;

    logic [31:0] d0_data, d1_data;
    logic        d0_vld, d1_vld;
    logic        d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un;
    logic        d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un;
    logic [4:0]  d0_count, d1_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [31:0] eq[$];
    bit          m_ov = 0, m_un = 0, m_vld = 0;
    int          m_n;

    always #5 clk = ~clk;

    status_fifo #(.FallThrough(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_data_o(d0_data), .rd_valid_o(d0_vld), .full_o(d0_full),
        .empty_o(d0_empty), .almost_full_o(d0_af), .almost_empty_o(d0_ae), .count_o(d0_count),
        .overflow_o(d0_ov), .underflow_o(d0_un));

    status_fifo #(.FallThrough(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_data_o(d1_data), .rd_valid_o(d1_vld), .full_o(d1_full),
        .empty_o(d1_empty), .almost_full_o(d1_af), .almost_empty_o(d1_ae), .count_o(d1_count),
        .overflow_o(d1_ov), .underflow_o(d1_un));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue plus flags, updated from the request rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); eq.delete();
            m_ov = 0; m_un = 0; m_vld = 0;
        end else if (flush) begin
            mq.delete();
            m_ov = 0; m_un = 0; m_vld = 0;
        end else begin
            m_n   = mq.size();
            m_vld = 0;
            if (wr_en && m_n == DEPTH) m_ov = 1;
            if (rd_en && m_n == 0)     m_un = 1;
            if (rd_en && m_n > 0) begin
                eq.push_back(mq.pop_front());
                m_vld = 1;
            end
            if (wr_en && m_n < DEPTH) mq.push_back(wr_data);
        end
    end

    // Monitor: compares every output of both instances on the falling edge.
    always @(negedge clk) begin : monitor
        int n;
        logic [5:0] exp_st;
        n = mq.size();
        exp_st = {n == DEPTH, n == 0, n >= 14, n <= 2, m_ov, m_un};
        chk("count0", d0_count, n);
        chk("count1", d1_count, n);
        chk("status0", {d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un}, exp_st);
        chk("status1", {d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un}, exp_st);
        chk("rd_valid0", d0_vld, m_vld);
        if (m_vld) begin
            if (eq.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty actual=valid expected=entry at %0t", $time);
            end else chk("rd_data0", d0_data, eq.pop_front());
        end
        chk("rd_valid1", d1_vld, n != 0);
        if (n != 0) chk("rd_data1", d1_data, mq[0]);
    end

    task automatic cyc(input bit w, input logic [31:0] d, input bit r, input bit f);
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0;
    endtask

    task automatic fill(input int k);
        for (int i = 0; i < k; i++) cyc(1, $urandom, 0, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int w, r, n, guard;
        bit dw, dr;
        rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; wr_data = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("rst_count", d0_count, 0);
        chk("rst_flags", {d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un, d0_vld}, 7'b0101000);
        chk("rst_data0", d0_data, 0);

        // Fill with 0x00..0x0F, then one overflowing write of 0xAA.
        for (int i = 0; i < 16; i++) begin
            cyc(1, i, 0, 0);
            if (i == 12) chk("af_at13", d0_af, 0);
            if (i == 13) chk("af_at14", d0_af, 1);
        end
        chk("fill_full", d0_full, 1);
        chk("fill_count", d0_count, 16);
        cyc(1, 32'hAA, 0, 0);
        chk("fill_ovf", d0_ov, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0);
            chk("drain_order", d0_data, i);
        end
        chk("drain_empty", d0_empty, 1);
        chk("drain_ae", d0_ae, 1);
        cyc(0, 0, 1, 0);
        chk("drain_unf", d0_un, 1);
        chk("drain_novld", d0_vld, 0);

        // Wrap-around with occupancy held between 1 and 3.
        cyc(0, 0, 0, 1);
        w = 0; r = 0; guard = 0;
        while ((w < 40 || r < 40) && guard < 2000) begin
            n = mq.size();
            dr = (r < 40) && (n >= 2 || (n == 1 && (w >= 40 || $urandom_range(0, 1) == 1)));
            dw = (w < 40) && ((n < 3 && $urandom_range(0, 1) == 1) || (dr && n == 1) || n == 0);
            w += int'(dw); r += int'(dr); guard++;
            cyc(dw, $urandom, dr, 0);
        end
        chk("wrap_done", {w[7:0], r[7:0]}, {8'd40, 8'd40});
        chk("wrap_noflags", {d0_ov, d0_un}, 2'b00);
        fill(5);
        cyc(1, $urandom, 1, 0);
        chk("simul_cnt5", d0_count, 5);

        // FWFT visibility.
        cyc(0, 0, 0, 1);
        cyc(1, 32'h1234, 0, 0);
        chk("fwft_vld", d1_vld, 1);
        chk("fwft_data", d1_data, 32'h1234);
        cyc(0, 0, 1, 0);
        chk("fwft_empty", {d1_empty, d1_vld}, 2'b10);

        // Full and empty boundaries with simultaneous requests.
        cyc(0, 0, 0, 1);
        fill(16);
        cyc(1, $urandom, 1, 0);
        chk("full_rw_cnt", d0_count, 15);
        chk("full_rw_ovf", d0_ov, 1);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
        cyc(1, $urandom, 1, 0);
        chk("empty_rw_cnt", d0_count, 1);
        chk("empty_rw_unf", d0_un, 1);

        // Flush with count 7 and both flags set; accompanying write ignored.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        fill(17);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
        chk("pre_flush", {d0_count, d0_ov, d0_un}, {5'd7, 2'b11});
        cyc(1, $urandom, 0, 1);
        chk("flush_state", {d0_count, d0_ov, d0_un, d0_vld}, {5'd0, 3'b000});

        // Random traffic, write-biased then read-biased, with rare flushes.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) < (i < 300 ? 70 : 35), $urandom,
                $urandom_range(0, 99) < (i < 300 ? 35 : 70), $urandom_range(0, 99) < 2);

        // Asynchronous reset in the middle of a write burst.
        fill(6);
        wr_en = 1; rd_en = 1; wr_data = $urandom;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_count", {d0_count, d1_count}, 10'd0);
        chk("arst_flags", {d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un, d0_vld}, 7'b0101000);
        chk("arst_fwft", {d1_empty, d1_vld}, 2'b10);
        chk("arst_data0", d0_data, 0);
        @(negedge clk);
        wr_en = 0; rd_en = 0;
        rst_n = 1;
        fill(3);
        repeat (3) cyc(0, 0, 1, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
